regfile_dump: RTL
=================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL use reset Reset, synchronous, active-high; clock Clk.
REQ-002 SHALL have port: Clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port: Reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: Start  input  1  single-cycle request to begin a dump of R0..R7.
REQ-005 SHALL have port: RegSel  output  3  register index driven to the register file SR1 select.
REQ-006 SHALL have port: RegData  input  16  combinational register-file read data for RegSel.
REQ-007 SHALL have port: OutValid  output  1  OutNibble/OutReg/OutDigit/OutLast hold a valid item.
REQ-008 SHALL have port: OutReady  input  1  consumer accepts the item this cycle.
REQ-009 SHALL have port: OutNibble  output  4  current hex digit, MSB nibble first.
REQ-010 SHALL have port: OutReg  output  3  register index of the current digit.
REQ-011 SHALL have port: OutDigit  output  2  digit position (0 = bits 15:12, 3 = bits 3:0).
REQ-012 SHALL have port: OutLast  output  1  high on the final digit (R7, digit 3).
REQ-013 SHALL have port: Busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port: Done  output  1  one-cycle pulse after the final digit is accepted.

Function
REQ-015 SHALL implement states IDLE, FETCH, SEND, DONE.
REQ-016 IDLE: on Start=1, SHALL clear reg counter to 0 and go to FETCH; otherwise remain.
REQ-017 FETCH: SHALL capture RegData into a 16-bit snapshot, clear digit counter to 0, and go to SEND; lasts exactly one cycle.
REQ-018 SEND: OutValid SHALL be 1; OutNibble SHALL equal snapshot digit selected by digit counter.
REQ-019 A transfer SHALL occur only when OutValid=1 and OutReady=1 in the same cycle.
REQ-020 While OutValid=1 and OutReady=0, all Out* outputs SHALL hold stable.
REQ-021 On transfer with digit<3: digit counter SHALL increment; stay in SEND.
REQ-022 On transfer with digit=3 and reg<7: reg counter SHALL increment; go to FETCH.
REQ-023 On transfer with digit=3 and reg=7: go to DONE; no wrap of reg counter.
REQ-024 DONE: Done SHALL be 1 for exactly one cycle; then IDLE.
REQ-025 RegSel SHALL equal the reg counter at all times; OutReg SHALL equal the reg counter.
REQ-026 Start while Busy=1 SHALL be ignored.
REQ-027 Changes to RegData after FETCH SHALL NOT affect the digits of that register.
REQ-028 Latency: Start at cycle N -> FETCH at N+1 -> first OutValid at N+2; with OutReady tied high, a full dump SHALL take 8x(1+4) cycles from first FETCH to Done=1, Done at cycle N+41.
REQ-029 OutValid, OutLast SHALL be 0 outside SEND; OutLast=1 only when reg=7, digit=3 in SEND.

Reset
REQ-030 Reset=1 SHALL force IDLE at the next edge regardless of state, including mid-dump.
REQ-031 After reset: RegSel=0, OutValid=0, OutNibble=0, OutReg=0, OutDigit=0, OutLast=0, Busy=0, Done=0, snapshot=16'h0000.
REQ-032 Reset SHALL take priority over Start and OutReady in the same cycle.

Structure
REQ-033 Package lc3_dump_pkg SHALL hold the state enum (IDLE, FETCH, SEND, DONE), NUM_REGS=8, DIGITS_PER_WORD=4.
REQ-034 The block SHALL be a single module; no sub-module is warranted.
REQ-035 Out* and RegSel SHALL be driven from registered state only; no combinational path from OutReady to OutValid.

Verification
REQ-036 Regfile model R0..R7 = 16'h1234, 16'hABCD, 0, 16'hFFFF, 16'h0001, 16'h8000, 16'h5A5A, 16'hC0DE; Start, OutReady=1 -> 32 digits 1,2,3,4,A,B,C,D,...,C,0,D,E; OutLast only on final E; Done at Start+41.
REQ-037 Same data, OutReady toggled 1,0,0,1 repeatedly -> identical digit sequence; Out* stable during every stall.
REQ-038 Change R1 from 16'hABCD to 16'h0000 one cycle after R1 FETCH -> R1 digits still A,B,C,D.
REQ-039 Assert Reset during SEND of R3 digit 2 -> next cycle IDLE, all outputs at reset values; new Start gives full dump from R0.
REQ-040 Pulse Start again during R5 SEND -> ignored; exactly 32 transfers and one Done pulse.

Source files
------------

// File: rtl/lc3_dump_pkg.sv
// ---------------------------------------------------------------------------
// lc3_dump_pkg
//   Shared definitions for the register-file hex dumper.
//   - dump_state_t : controller states (IDLE, FETCH, SEND, DONE)
//   - NUM_REGS, DIGITS_PER_WORD : dump geometry (8 registers x 4 hex digits)
//   - hex_digit()  : picks one nibble of a 16-bit word, position 0 = MSB nibble
// ---------------------------------------------------------------------------
package lc3_dump_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } dump_state_t;

   localparam int NUM_REGS        = 8;
   localparam int DIGITS_PER_WORD = 4;

   localparam logic [2:0] LAST_REG   = 3'(NUM_REGS - 1);
   localparam logic [1:0] LAST_DIGIT = 2'(DIGITS_PER_WORD - 1);

   // Position 0 is bits 15:12, position 3 is bits 3:0. For a 2-bit position,
   // ~pos equals (3 - pos), so the word is shifted right by 4*(3 - pos).
   function automatic logic [3:0] hex_digit(input logic [15:0] word,
                                            input logic [1:0]  pos);
      logic [15:0] shifted;
      shifted = word >> {~pos, 2'b00};
      return shifted[3:0];
   endfunction

endpackage

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//   Walks registers R0..R7 of an LC-3 style register file and streams each
//   one out as four hex digits (MSB nibble first) over a valid/ready port.
//   Each register is read once into a snapshot, so later changes to the
//   register file do not disturb the digits of a register already fetched.
//
// Ports
//   Clk        in   system clock, all state changes on posedge
//   Reset      in   synchronous active-high reset
//   Start      in   single-cycle request to begin a dump (ignored while Busy)
//   RegSel     out  [2:0]  register index to the register-file read port
//   RegData    in   [15:0] combinational read data for RegSel
//   OutValid   out  an item is presented on OutNibble/OutReg/OutDigit/OutLast
//   OutReady   in   consumer accepts the item this cycle
//   OutNibble  out  [3:0]  current hex digit
//   OutReg     out  [2:0]  register the digit belongs to
//   OutDigit   out  [1:0]  digit position (0 = bits 15:12)
//   OutLast    out  final digit of the dump (R7, digit 3)
//   Busy       out  controller is not idle
//   Done       out  one-cycle pulse after the final digit is accepted
// ---------------------------------------------------------------------------
module regfile_dump
   import lc3_dump_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   output logic [2:0]  RegSel,
   input  logic [15:0] RegData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [3:0]  OutNibble,
   output logic [2:0]  OutReg,
   output logic [1:0]  OutDigit,
   output logic        OutLast,
   output logic        Busy,
   output logic        Done
);

   dump_state_t state_reg,     state_next;
   logic [2:0]  reg_cnt_reg,   reg_cnt_next;
   logic [1:0]  digit_cnt_reg, digit_cnt_next;
   logic [15:0] snapshot_reg,  snapshot_next;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg     <= IDLE;
         reg_cnt_reg   <= '0;
         digit_cnt_reg <= '0;
         snapshot_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         reg_cnt_reg   <= reg_cnt_next;
         digit_cnt_reg <= digit_cnt_next;
         snapshot_reg  <= snapshot_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      reg_cnt_next   = reg_cnt_reg;
      digit_cnt_next = digit_cnt_reg;
      snapshot_next  = snapshot_reg;

      case (state_reg)
         IDLE: begin
            if (Start) begin
               reg_cnt_next = '0;
               state_next   = FETCH;
            end
         end

         FETCH: begin
            snapshot_next  = RegData;
            digit_cnt_next = '0;
            state_next     = SEND;
         end

         SEND: begin
            if (OutReady) begin
               if (digit_cnt_reg != LAST_DIGIT) begin
                  digit_cnt_next = digit_cnt_reg + 2'd1;
               end else if (reg_cnt_reg != LAST_REG) begin
                  reg_cnt_next = reg_cnt_reg + 3'd1;
                  state_next   = FETCH;
               end else begin
                  // Counter stays at R7 so OutReg/RegSel do not wrap to R0
                  // during the DONE cycle.
                  state_next = DONE;
               end
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // All outputs decode registered state only; OutReady never reaches them
   // combinationally, so they hold still across a stall by construction.
   assign RegSel    = reg_cnt_reg;
   assign OutReg    = reg_cnt_reg;
   assign OutDigit  = digit_cnt_reg;
   assign OutNibble = hex_digit(snapshot_reg, digit_cnt_reg);
   assign OutValid  = (state_reg == SEND);
   assign OutLast   = (state_reg == SEND) && (reg_cnt_reg == LAST_REG) &&
                      (digit_cnt_reg == LAST_DIGIT);
   assign Busy      = (state_reg != IDLE);
   assign Done      = (state_reg == DONE);

endmodule
